fmul_issue_arbiter: RTL and testbench

Round-robin issue arbiter that shares one single-precision floating-point multiplier among `N_REQ` requesters. Each cycle it accepts at most one operand pair, registers it onto the multiplier inputs, and tracks the requester tag through a shadow pipeline matching the multiplier latency. It returns the product, the `error` flag and the `overflow` flag to the requester that issued it. It sits between the vector/scalar front-ends and the shared multiplier datapath.

---
 rtl/fmul_issue_arbiter_if.sv | 67 ++++++
 rtl/fmul_issue_arbiter.sv | 147 ++++++++++++++
 tb/tb_fmul_issue_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmul_issue_arbiter_if.sv
// Requester, multiplier and response bundle for the shared FP multiplier
// arbiter; the arbiter takes the slave side.
interface fmul_issue_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int LAT   = 2
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(LAT + 3);

  logic                  en;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*32-1:0]   req_a;
  logic [N_REQ*32-1:0]   req_b;
  logic [N_REQ-1:0]      req_ready;
  logic [31:0]           mul_op_a;
  logic [31:0]           mul_op_b;
  logic                  mul_issue;
  logic [31:0]           mul_res;
  logic                  mul_error;
  logic                  mul_overflow;
  logic                  resp_valid;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_data;
  logic                  resp_error;
  logic                  resp_overflow;
  logic [CNT_W-1:0]      inflight;

  modport slave (
    input  en,
    input  req_valid,
    input  req_a,
    input  req_b,
    input  mul_res,
    input  mul_error,
    input  mul_overflow,
    output req_ready,
    output mul_op_a,
    output mul_op_b,
    output mul_issue,
    output resp_valid,
    output resp_id,
    output resp_data,
    output resp_error,
    output resp_overflow,
    output inflight
  );

  modport master (
    output en,
    output req_valid,
    output req_a,
    output req_b,
    output mul_res,
    output mul_error,
    output mul_overflow,
    input  req_ready,
    input  mul_op_a,
    input  mul_op_b,
    input  mul_issue,
    input  resp_valid,
    input  resp_id,
    input  resp_data,
    input  resp_error,
    input  resp_overflow,
    input  inflight
  );
endinterface

// File: rtl/fmul_issue_arbiter.sv
// Round-robin issue arbiter sharing one pipelined FP multiplier;
// a tag shadow pipeline routes each product back to its requester.
module fmul_issue_arbiter #(
  parameter int N_REQ = 4,
  parameter int LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fmul_issue_arbiter_if.slave   bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int SW    = ID_W + 1;
  localparam int CNT_W = $clog2(LAT + 3);

  logic [ID_W-1:0]        rr_ptr_q;
  logic [ID_W-1:0]        rr_ptr_d;
  logic [N_REQ-1:0]       gnt;
  logic [ID_W-1:0]        gnt_id;
  logic                   hs;
  logic [SW-1:0]          scan;

  logic [31:0]            op_a_q;
  logic [31:0]            op_b_q;
  logic [LAT:0]           sv_q;
  logic [LAT:0][ID_W-1:0] sid_q;

  logic                   rv_q;
  logic [ID_W-1:0]        rid_q;
  logic [31:0]            rdata_q;
  logic                   rerr_q;
  logic                   rovf_q;
  logic [CNT_W-1:0]       infl_q;
  logic [CNT_W-1:0]       infl_d;

  // Scan upward from rr_ptr_q with wrap; first valid requester wins
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    hs     = 1'b0;
    scan   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan = {1'b0, rr_ptr_q} + SW'(k);
      if (scan >= SW'(N_REQ))
        scan = scan - SW'(N_REQ);
      if (!hs && rst_n && bus.en &&
          bus.req_valid[scan[ID_W-1:0]]) begin
        hs     = 1'b1;
        gnt_id = scan[ID_W-1:0];
      end
    end
    if (hs)
      gnt[gnt_id] = 1'b1;
  end

  // Pointer moves just past the winner, holds when idle
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (hs) begin
      if (gnt_id == ID_W'(N_REQ - 1))
        rr_ptr_d = '0;
      else
        rr_ptr_d = gnt_id + 1'b1;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr_q <= '0;
    else
      rr_ptr_q <= rr_ptr_d;
  end

  // Operands only load on a grant so idle cycles do not toggle the multiplier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q <= '0;
      op_b_q <= '0;
    end else if (hs) begin
      op_a_q <= bus.req_a[32*gnt_id +: 32];
      op_b_q <= bus.req_b[32*gnt_id +: 32];
    end
  end

  // Stage 0 is the issue tag; stages 1..LAT track the multiplier pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv_q  <= '0;
      sid_q <= '0;
    end else begin
      sv_q[0]  <= hs;
      sid_q[0] <= gnt_id;
      for (int k = 1; k <= LAT; k++) begin
        sv_q[k]  <= sv_q[k-1];
        sid_q[k] <= sid_q[k-1];
      end
    end
  end

  // Capture product and flags when the last shadow stage is live
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_q    <= 1'b0;
      rid_q   <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
      rovf_q  <= 1'b0;
    end else begin
      rv_q <= sv_q[LAT];
      if (sv_q[LAT]) begin
        rid_q   <= sid_q[LAT];
        rdata_q <= bus.mul_res;
        rerr_q  <= bus.mul_error;
        rovf_q  <= bus.mul_overflow;
      end
    end
  end

  // Accepted-but-unreturned count; simultaneous in and out cancel
  always_comb begin
    infl_d = infl_q;
    if (hs && !rv_q)
      infl_d = infl_q + 1'b1;
    else if (!hs && rv_q)
      infl_d = infl_q - 1'b1;
  end

  // Inflight counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      infl_q <= '0;
    else
      infl_q <= infl_d;
  end

  assign bus.req_ready     = gnt;
  assign bus.mul_op_a      = op_a_q;
  assign bus.mul_op_b      = op_b_q;
  assign bus.mul_issue     = sv_q[0];
  assign bus.resp_valid    = rv_q;
  assign bus.resp_id       = rid_q;
  assign bus.resp_data     = rdata_q;
  assign bus.resp_error    = rerr_q;
  assign bus.resp_overflow = rovf_q;
  assign bus.inflight      = infl_q;

endmodule

// File: tb/tb_fmul_issue_arbiter.sv
// Bench for fmul_issue_arbiter: directed scenarios plus random traffic
// against a queue-based reference of grants and due responses.
module tb_fmul_issue_arbiter;
  localparam int N = 4;
  localparam int L = 2;

  typedef struct {
    int          due;
    int          id;
    logic [33:0] r;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fmul_issue_arbiter_if #(.N_REQ(N), .LAT(L)) bus ();

  fmul_issue_arbiter #(.N_REQ(N), .LAT(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Stand-in multiplier: {overflow, error, result}
  function automatic logic [33:0] fm(logic [31:0] a, logic [31:0] b);
    if (a == 32'h40000000 && b == 32'h40400000)
      return {2'b00, 32'h40C00000};
    if ((a[30:0] == 31'h7F800000 && b[30:0] == 31'h0) ||
        (b[30:0] == 31'h7F800000 && a[30:0] == 31'h0))
      return {1'b0, 1'b1, 32'h7FC00000};
    return {a[0] ^ b[0], 1'b0, a ^ {b[15:0], b[31:16]}};
  endfunction

  logic [33:0] mp [L];

  // Multiplier pipeline of depth L fed from the registered operands
  always @(posedge clk) begin
    mp[0] <= fm(bus.mul_op_a, bus.mul_op_b);
    for (int k = 1; k < L; k++)
      mp[k] <= mp[k-1];
  end

  assign bus.mul_res      = mp[L-1][31:0];
  assign bus.mul_error    = mp[L-1][32];
  assign bus.mul_overflow = mp[L-1][33];

  int          nchk;
  int          nfail;
  int          cyc;
  int          rr;
  exp_t        q[$];
  bit          m_issue;
  logic [31:0] m_opa;
  logic [31:0] m_opb;
  int          m_rid;
  logic [31:0] m_rdata;
  bit          m_rerr;
  bit          m_rovf;

  logic        en_v;
  logic [N-1:0] vld;
  logic [31:0] av [N];
  logic [31:0] bv [N];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h want %h cyc %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    int   g;
    int   infl;
    bit   rv;
    exp_t e;
    bus.en        = en_v;
    bus.req_valid = vld;
    bus.req_a     = {av[3], av[2], av[1], av[0]};
    bus.req_b     = {bv[3], bv[2], bv[1], bv[0]};
    @(negedge clk);
    g = -1;
    if (en_v)
      for (int k = 0; k < N; k++)
        if (g < 0 && vld[(rr + k) % N])
          g = (rr + k) % N;
    chk("req_ready", 32'(bus.req_ready),
        (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("mul_issue", 32'(bus.mul_issue), 32'(m_issue));
    chk("mul_op_a", bus.mul_op_a, m_opa);
    chk("mul_op_b", bus.mul_op_b, m_opb);
    infl = q.size();
    rv = (q.size() > 0) && (q[0].due == cyc);
    chk("resp_valid", 32'(bus.resp_valid), 32'(rv));
    if (rv) begin
      e       = q.pop_front();
      m_rid   = e.id;
      m_rdata = e.r[31:0];
      m_rerr  = e.r[32];
      m_rovf  = e.r[33];
    end
    chk("resp_id", 32'(bus.resp_id), 32'(m_rid));
    chk("resp_data", bus.resp_data, m_rdata);
    chk("resp_error", 32'(bus.resp_error), 32'(m_rerr));
    chk("resp_ovf", 32'(bus.resp_overflow), 32'(m_rovf));
    chk("inflight", 32'(bus.inflight), 32'(infl));
    if (g >= 0) begin
      q.push_back('{cyc + L + 2, g, fm(av[g], bv[g])});
      rr      = (g + 1) % N;
      m_issue = 1'b1;
      m_opa   = av[g];
      m_opb   = bv[g];
    end else begin
      m_issue = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_mul_issue", 32'(bus.mul_issue), 32'd0);
    chk("rst_op_a", bus.mul_op_a, 32'd0);
    chk("rst_op_b", bus.mul_op_b, 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_resp_err", 32'(bus.resp_error), 32'd0);
    chk("rst_resp_ovf", 32'(bus.resp_overflow), 32'd0);
    chk("rst_inflight", 32'(bus.inflight), 32'd0);
    q.delete();
    rr      = 0;
    m_issue = 1'b0;
    m_opa   = '0;
    m_opb   = '0;
    m_rid   = 0;
    m_rdata = '0;
    m_rerr  = 1'b0;
    m_rovf  = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    nchk  = 0;
    nfail = 0;
    cyc   = 0;
    rst_n = 1'b0;
    en_v  = 1'b1;
    vld   = '0;
    for (int i = 0; i < N; i++) begin
      av[i] = '0;
      bv[i] = '0;
    end
    bus.en        = en_v;
    bus.req_valid = vld;
    bus.req_a     = '0;
    bus.req_b     = '0;
    @(posedge clk);
    #1;
    do_reset();

    // single request from requester 2 in cycle 5
    repeat (5) step();
    vld   = 4'b0100;
    av[2] = 32'h40000000;
    bv[2] = 32'h40400000;
    step();
    vld = '0;
    repeat (6) step();
    chk("single_data", bus.resp_data, 32'h40C00000);
    chk("single_id", 32'(bus.resp_id), 32'd2);

    // fairness from pointer 0
    do_reset();
    vld = 4'hF;
    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < N; i++) begin
        av[i] = $urandom;
        bv[i] = $urandom;
      end
      step();
    end
    vld = '0;
    repeat (6) step();
    chk("fair_drain", 32'(bus.inflight), 32'd0);

    // sparse wrap: move pointer to 2, then only 3 and 1 valid
    vld   = 4'b0010;
    av[1] = 32'h3F800000;
    bv[1] = 32'h40800000;
    step();
    vld   = 4'b1010;
    av[3] = 32'hC0000000;
    bv[3] = 32'h3F000000;
    repeat (3) step();
    vld = '0;
    repeat (6) step();

    // en gating with two in flight
    vld   = 4'b0001;
    av[0] = 32'h41200000;
    bv[0] = 32'h41A00000;
    repeat (2) step();
    en_v = 1'b0;
    repeat (3) step();
    en_v = 1'b1;
    vld  = '0;
    repeat (4) step();
    chk("en_drain", 32'(bus.inflight), 32'd0);

    // Inf x 0 error flag passthrough
    vld   = 4'b0010;
    av[1] = 32'h7F800000;
    bv[1] = 32'h00000000;
    step();
    vld = '0;
    repeat (4) step();
    chk("flag_err", 32'(bus.resp_error), 32'd1);
    chk("flag_ovf", 32'(bus.resp_overflow), 32'd0);
    chk("flag_data", bus.resp_data, 32'h7FC00000);

    // random traffic
    for (int s = 0; s < 300; s++) begin
      en_v = ($urandom_range(0, 7) != 0);
      vld  = N'($urandom);
      for (int i = 0; i < N; i++) begin
        av[i] = $urandom;
        bv[i] = $urandom;
        if ($urandom_range(0, 9) == 0) av[i] = 32'h7F800000;
        if ($urandom_range(0, 9) == 0) bv[i] = 32'h00000000;
      end
      step();
    end
    en_v = 1'b1;
    vld  = '0;
    repeat (6) step();

    // reset with three in flight
    vld = 4'hF;
    repeat (3) step();
    do_reset();
    vld   = 4'b1010;
    av[1] = 32'h40000000;
    bv[1] = 32'h40400000;
    step();
    vld = '0;
    repeat (6) step();
    chk("post_rst_id", 32'(bus.resp_id), 32'd1);
    chk("post_rst_infl", 32'(bus.inflight), 32'd0);

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end
endmodule
